// File: rtl/pulse_stretcher_if.sv
// Event-to-pulse stretcher signal bundle.
// Latency: none (wires only).
// Backpressure: none; requests the stretcher cannot hold are reported on drop_o.
//
// Signals:
//   trig_i      request pulse, one request per cycle sampled high
//   level_o     stretched output pulse
//   busy_o      stretcher is in a pulse or in the enforced low gap
//   drop_o      one-cycle flag, a request was discarded
//   pulse_cnt_o count of output pulses started (wraps)
//
// Modports: master drives trig_i (event source), slave is the stretcher.
interface pulse_stretcher_if #(
  parameter int CNT_W = 8
);
  logic             trig_i;
  logic             level_o;
  logic             busy_o;
  logic             drop_o;
  logic [CNT_W-1:0] pulse_cnt_o;

  modport master (
    output trig_i,
    input  level_o,
    input  busy_o,
    input  drop_o,
    input  pulse_cnt_o
  );

  modport slave (
    input  trig_i,
    output level_o,
    output busy_o,
    output drop_o,
    output pulse_cnt_o
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle requests into PULSE_LEN-cycle pulses separated by at least GAP_LEN low cycles.
// Latency: request sampled at edge t drives level_o high for cycles t+1 .. t+PULSE_LEN.
// Backpressure: one request is held pending while busy; further requests are discarded and flagged on drop_o.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; forces all outputs low immediately
//   ps   pulse_stretcher_if.slave: trig_i in; level_o, busy_o, drop_o, pulse_cnt_o out (all registered)
//
// Optional feature macro: PULSE_STRETCHER_RETRIGGER_EN
//   When defined, a request during HIGH reloads the pulse counter (extends the pulse)
//   instead of going through the pending/drop path.
module pulse_stretcher #(
  parameter int PULSE_LEN = 8,
  parameter int GAP_LEN   = 2,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  pulse_stretcher_if.slave   ps
);

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             drop_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             level_q, busy_q, drop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;
    pcnt_d  = pcnt_q;

    case (state_q)
      IDLE: begin
        if (ps.trig_i) begin
          state_d = HIGH;
          cnt_d   = PULSE_LOAD;
          pcnt_d  = pcnt_q + 1'b1;
        end
      end

      HIGH: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        // Retrigger wins over the end-of-pulse transition so the pulse is
        // extended even when the request lands on the last high cycle.
        if (ps.trig_i) begin
          cnt_d = PULSE_LOAD;
        end else if (cnt_q == 8'd0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
`else
        if (cnt_q == 8'd0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
        if (ps.trig_i) begin
          if (pend_q) drop_d = 1'b1;
          else        pend_d = 1'b1;
        end
`endif
      end

      GAP: begin
        if (cnt_q == 8'd0) begin
          if (pend_q || ps.trig_i) begin
            state_d = HIGH;
            cnt_d   = PULSE_LOAD;
            pcnt_d  = pcnt_q + 1'b1;
            // Pending starts this pulse; a simultaneous request takes its slot.
            pend_d  = pend_q & ps.trig_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (ps.trig_i) begin
            if (pend_q) drop_d = 1'b1;
            else        pend_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      pend_q  <= 1'b0;
      pcnt_q  <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pcnt_q  <= pcnt_d;
      // Output flops mirror the next state so they align with state_q
      // while staying free of any combinational path from trig_i.
      level_q <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
      drop_q  <= drop_d;
    end
  end

  assign ps.level_o     = level_q;
  assign ps.busy_o      = busy_q;
  assign ps.drop_o      = drop_q;
  assign ps.pulse_cnt_o = pcnt_q;

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses, e.g. from the team's edge detectors, into fixed-width output pulses of PULSE_LEN cycles.
- Enforces a minimum low gap of GAP_LEN cycles between output pulses.
- Holds one pending request while busy and flags requests it cannot hold.
- Sits between event-detection logic and slow consumers: LEDs, off-chip strobes, slow-domain synchronisers.

Parameters:
PULSE_LEN, 8, output high time in clk cycles; legal range 1..255
GAP_LEN, 2, minimum output low time between consecutive pulses in clk cycles; legal range 1..255
CNT_W, 8, pulse counter width in bits

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset, asynchronous, active-high
trig_i  input  1  request; each cycle sampled high is one request (no internal edge detection)
level_o  output  1  stretched pulse, registered
busy_o  output  1  high in any state other than IDLE, registered
drop_o  output  1  one-cycle flag: a request was discarded, registered
pulse_cnt_o  output  CNT_W  number of output pulses started; wraps modulo 2^CNT_W

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- While rst is high:
  - state = IDLE, counter = 0, pending = 0.
  - level_o = 0, busy_o = 0, drop_o = 0, pulse_cnt_o = 0.
- Reset asserted mid-pulse or mid-gap forces level_o low immediately, not waiting for a clock edge. Any pending request is lost.
- States:
  - IDLE: level_o = 0.
    - trig_i = 1 → load counter with PULSE_LEN-1, go to HIGH.
    - pulse_cnt_o increments on that edge.
  - HIGH: level_o = 1, counter decrements each cycle.
    - At counter = 0 → load counter with GAP_LEN-1, go to GAP.
  - GAP: level_o = 0, counter decrements each cycle.
    - At counter = 0 with pending = 1 or trig_i = 1 → go to HIGH, reload PULSE_LEN-1, clear pending, increment pulse_cnt_o.
    - At counter = 0 otherwise → go to IDLE.
- Latency: trig_i sampled high at edge t while IDLE → level_o high for exactly cycles t+1 .. t+PULSE_LEN.
  - Earliest next rising edge of level_o is cycle t+PULSE_LEN+GAP_LEN+1.
- Requests while busy (HIGH, or GAP not on its final cycle):
  - pending = 0 → set pending = 1; no drop.
  - pending = 1 → request discarded; drop_o = 1 in the next cycle.
- Final GAP cycle with both pending = 1 and trig_i = 1:
  - Pending is consumed to start the new pulse.
  - trig_i becomes the new pending.
  - No drop.
- Every output is driven from a flop; no combinational path from trig_i to any output.
- busy_o = 1 exactly when state is HIGH or GAP.
- pulse_cnt_o wraps from 2^CNT_W-1 to 0 silently.
- Unreachable state encoding → IDLE on the next edge.

Optional Feature:
- Macro: PULSE_STRETCHER_RETRIGGER_EN.
- Defined:
  - trig_i = 1 while in HIGH reloads the counter with PULSE_LEN-1, extending the current pulse.
  - It does not set pending, does not increment pulse_cnt_o, and never asserts drop_o.
  - Requests during GAP keep the pending/drop rules above.
- Not defined: the pending/drop rules above apply unchanged in HIGH.

Test Plan:
- PULSE_LEN=8, GAP_LEN=2: one-cycle trig_i at cycle 10 → level_o high cycles 11..18, low from 19, busy_o low from 21; pulse_cnt_o = 1; drop_o never set.
- Trig at cycle 10 and cycle 14 → pulses on cycles 11..18 and 21..28; pulse_cnt_o = 2; no drop.
- Trig at cycles 10, 13, 15 → pulses on cycles 11..18 and 21..28; drop_o high at cycle 16 only; pulse_cnt_o = 2.
- rst asserted asynchronously mid-cycle 14 after trig at 10 → level_o and busy_o fall immediately; pulse_cnt_o = 0; after release, trig produces a normal 8-cycle pulse.
- PULSE_LEN=1, GAP_LEN=1: trig_i held high for 6 cycles from cycle 0 → level_o toggles 1,0,1,0,1,0 starting cycle 1; drop_o asserted once requests overflow pending; pulse_cnt_o counts only started pulses.
- PULSE_STRETCHER_RETRIGGER_EN defined: trig at cycle 10 and 15 → level_o high cycles 11..23 as one pulse; pulse_cnt_o = 1; drop_o never set.
